ff_excitation_driver: RTL and testbench
=======================================

FF_EXCITATION_DRIVER -- requirements
Module: ff_excitation_driver

Interface
REQ-001 Parameter: CNT_W, 8, width of the transition and toggle counters.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 tgt_valid  input  1  requested next flip-flop state is present.
REQ-005 tgt_q  input  1  requested next flip-flop state.
REQ-006 tgt_ready  output  1  block accepts a request; high only in IDLE.
REQ-007 clr_err  input  1  clears the sticky mismatch flag.
REQ-008 exc_s, exc_r, exc_j, exc_k, exc_t, exc_d  output  1 each  registered excitation for the accepted transition.
REQ-009 q_sr, q_jk, q_t  output  1 each  internal SR, JK and T flip-flop model states.
REQ-010 exc_valid  output  1  high for the single CHECK-state cycle.
REQ-011 mismatch  output  1  sticky flag: a model state differed from the target.
REQ-012 trans_cnt  output  CNT_W  count of completed transitions.
REQ-013 toggle_cnt  output  CNT_W  count of completed transitions where the state changed.

Function
REQ-014 The FSM SHALL have three states, IDLE -> APPLY -> CHECK -> IDLE; each non-IDLE state lasts exactly one cycle.
REQ-015 In IDLE, a handshake (tgt_valid & tgt_ready) SHALL register tgt_q and the excitation, then move to APPLY; without a handshake the FSM stays in IDLE.
REQ-016 Excitation SHALL be computed from current q_t and tgt_q: exc_t = q_t XOR tgt_q; exc_d = tgt_q.
REQ-017 Default SR/JK resolution: 0->0: S=R=J=K=0; 0->1: S=J=1, R=K=0; 1->0: R=K=1, S=J=0; 1->1: S=R=J=K=0.
REQ-018 exc_s and exc_r SHALL never both be 1 in any mode.
REQ-019 In APPLY, the SR model SHALL load exc_s/exc_r, the JK model exc_j/exc_k (11 = toggle), and the T model exc_t, all at the closing edge of APPLY.
REQ-020 In CHECK, exc_valid SHALL be 1; at the closing edge, mismatch SHALL set if any of q_sr, q_jk, q_t differs from the registered target.
REQ-021 At the closing edge of CHECK, trans_cnt SHALL increment and wrap at 2^CNT_W.
REQ-022 At the closing edge of CHECK, toggle_cnt SHALL increment if exc_t = 1 and saturate at 2^CNT_W-1.
REQ-023 clr_err SHALL clear mismatch at the next edge; if a mismatch set and clr_err coincide, set SHALL win.
REQ-024 tgt_valid/tgt_q outside IDLE SHALL be ignored; throughput is one transition per 3 cycles.
REQ-025 exc_* SHALL hold their last value until the next handshake.

Reset
REQ-026 While rst_n = 0, the FSM SHALL be in IDLE, and tgt_ready SHALL be 1.
REQ-027 While rst_n = 0, all exc_*, q_sr, q_jk, q_t, exc_valid, mismatch and both counters SHALL be 0.
REQ-028 Reset asserted mid-transaction SHALL abort the transaction with no counter or flag update; the first post-reset request starts from q = 0.

Configuration
REQ-029 With FF_EXC_DONTCARE_ONE_EN defined, don't-care excitation terms SHALL resolve to 1.
REQ-030 Under FF_EXC_DONTCARE_ONE_EN, SR: 0->0 gives S=0,R=1; 1->1 gives S=1,R=0.
REQ-031 Under FF_EXC_DONTCARE_ONE_EN, JK: 0->0 gives J=0,K=1; 0->1 gives J=1,K=1; 1->0 gives J=1,K=1; 1->1 gives J=1,K=0.
REQ-032 Without FF_EXC_DONTCARE_ONE_EN, REQ-017 applies; in both modes, mismatch SHALL stay 0 for legal operation.

Verification
REQ-033 Reset, then tgt_q sequence 1,1,0,0,1 -> exc_valid pulses every 3rd cycle, exc_t = 1,0,1,0,1, toggle_cnt = 3, trans_cnt = 5, mismatch = 0.
REQ-034 tgt_valid held high continuously for 12 cycles -> exactly 4 handshakes; tgt_ready = 0 in APPLY/CHECK.
REQ-035 CNT_W = 2, 5 toggling transitions -> trans_cnt = 1 (wrapped), toggle_cnt = 3 (saturated).
REQ-036 With FF_EXC_DONTCARE_ONE_EN, 0->1 then 1->0 -> exc_j = exc_k = 1 both times, q_jk = 1 then 0, exc_s & exc_r = 0 throughout.
REQ-037 rst_n pulsed low during APPLY after accepting tgt_q = 1 -> all outputs 0, counters unchanged at 0, next request tgt_q = 1 gives exc_t = 1.
REQ-038 Force q_t model to an incorrect value in CHECK with clr_err = 1 the same cycle -> mismatch = 1; clr_err alone next cycle -> mismatch = 0.

Source files
------------

// File: rtl/ff_excitation_driver.sv
// ff_excitation_driver
//
// Purpose: accepts a requested next flip-flop state and computes the
// excitation needed by SR, JK, T and D flip-flops to reach it. It then
// applies that excitation to internal SR/JK/T models and checks that every
// model reached the target. Each transition takes three cycles:
// IDLE (handshake) -> APPLY (models load) -> CHECK (compare, count).
//
// Handshake: a request is accepted on a rising edge where
// tgt_valid & tgt_ready are both 1. tgt_ready is 1 only in IDLE.
// tgt_valid/tgt_q are ignored in every other cycle. The requester does not
// need to hold tgt_valid, and nothing is buffered.
//
// Optional feature: define FF_EXC_DONTCARE_ONE_EN to resolve don't-care
// SR/JK excitation terms to 1 instead of 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tgt_valid, tgt_q    request valid, requested next state
//   tgt_ready           request accepted (IDLE only)
//   clr_err             clear sticky mismatch (set has priority)
//   exc_s..exc_d        registered excitation of the last accepted request
//   q_sr, q_jk, q_t     flip-flop model states
//   exc_valid           high during the CHECK cycle
//   mismatch            sticky: a model missed its target
//   trans_cnt           completed transitions (wraps)
//   toggle_cnt          completed transitions that changed state (saturates)
//   dbg_state           current FSM state (0 IDLE, 1 APPLY, 2 CHECK)
module ff_excitation_driver #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    input  logic             tgt_q,
    output logic             tgt_ready,
    input  logic             clr_err,
    output logic             exc_s,
    output logic             exc_r,
    output logic             exc_j,
    output logic             exc_k,
    output logic             exc_t,
    output logic             exc_d,
    output logic             q_sr,
    output logic             q_jk,
    output logic             q_t,
    output logic             exc_valid,
    output logic             mismatch,
    output logic [CNT_W-1:0] trans_cnt,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic tgt_reg_q, tgt_reg_d;
    logic exc_s_q, exc_s_d, exc_r_q, exc_r_d, exc_j_q, exc_j_d;
    logic exc_k_q, exc_k_d, exc_t_q, exc_t_d, exc_d_q, exc_d_d;
    logic q_sr_q, q_sr_d, q_jk_q, q_jk_d, q_t_q, q_t_d;
    logic mismatch_q, mismatch_d;
    logic [CNT_W-1:0] trans_cnt_q, trans_cnt_d, toggle_cnt_q, toggle_cnt_d;

    logic hs;
    logic nxt_s, nxt_r, nxt_j, nxt_k;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (hs) state_d = ST_APPLY;
            ST_APPLY: state_d = ST_CHECK;
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        tgt_ready = (state_q == ST_IDLE);
        exc_valid = (state_q == ST_CHECK);
        dbg_state = state_q;
    end

    assign hs = tgt_valid & tgt_ready;

    // Excitation from present state (q_t model) to the requested state.
    // Don't-care terms are 0 by default. With FF_EXC_DONTCARE_ONE_EN they
    // are 1, but S and R are still never both 1.
    always_comb begin
`ifdef FF_EXC_DONTCARE_ONE_EN
        nxt_s = tgt_q;
        nxt_r = ~tgt_q;
        nxt_j = q_t_q | tgt_q;
        nxt_k = ~(q_t_q & tgt_q);
`else
        nxt_s = ~q_t_q & tgt_q;
        nxt_r = q_t_q & ~tgt_q;
        nxt_j = ~q_t_q & tgt_q;
        nxt_k = q_t_q & ~tgt_q;
`endif
    end

    // Datapath next-state
    always_comb begin
        tgt_reg_d    = tgt_reg_q;
        exc_s_d      = exc_s_q;
        exc_r_d      = exc_r_q;
        exc_j_d      = exc_j_q;
        exc_k_d      = exc_k_q;
        exc_t_d      = exc_t_q;
        exc_d_d      = exc_d_q;
        q_sr_d       = q_sr_q;
        q_jk_d       = q_jk_q;
        q_t_d        = q_t_q;
        mismatch_d   = mismatch_q;
        trans_cnt_d  = trans_cnt_q;
        toggle_cnt_d = toggle_cnt_q;

        if (clr_err) mismatch_d = 1'b0;

        if (hs) begin
            tgt_reg_d = tgt_q;
            exc_s_d   = nxt_s;
            exc_r_d   = nxt_r;
            exc_j_d   = nxt_j;
            exc_k_d   = nxt_k;
            exc_t_d   = q_t_q ^ tgt_q;
            exc_d_d   = tgt_q;
        end

        if (state_q == ST_APPLY) begin
            if (exc_s_q)      q_sr_d = 1'b1;
            else if (exc_r_q) q_sr_d = 1'b0;
            case ({exc_j_q, exc_k_q})
                2'b01:   q_jk_d = 1'b0;
                2'b10:   q_jk_d = 1'b1;
                2'b11:   q_jk_d = ~q_jk_q;
                default: q_jk_d = q_jk_q;
            endcase
            q_t_d = q_t_q ^ exc_t_q;
        end

        if (state_q == ST_CHECK) begin
            // A set in the same cycle overrides clr_err.
            if ((q_sr_q != tgt_reg_q) || (q_jk_q != tgt_reg_q) || (q_t_q != tgt_reg_q))
                mismatch_d = 1'b1;
            trans_cnt_d = trans_cnt_q + 1'b1;
            if (exc_t_q && (toggle_cnt_q != {CNT_W{1'b1}}))
                toggle_cnt_d = toggle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_reg_q    <= 1'b0;
            exc_s_q      <= 1'b0;
            exc_r_q      <= 1'b0;
            exc_j_q      <= 1'b0;
            exc_k_q      <= 1'b0;
            exc_t_q      <= 1'b0;
            exc_d_q      <= 1'b0;
            q_sr_q       <= 1'b0;
            q_jk_q       <= 1'b0;
            q_t_q        <= 1'b0;
            mismatch_q   <= 1'b0;
            trans_cnt_q  <= '0;
            toggle_cnt_q <= '0;
        end else begin
            tgt_reg_q    <= tgt_reg_d;
            exc_s_q      <= exc_s_d;
            exc_r_q      <= exc_r_d;
            exc_j_q      <= exc_j_d;
            exc_k_q      <= exc_k_d;
            exc_t_q      <= exc_t_d;
            exc_d_q      <= exc_d_d;
            q_sr_q       <= q_sr_d;
            q_jk_q       <= q_jk_d;
            q_t_q        <= q_t_d;
            mismatch_q   <= mismatch_d;
            trans_cnt_q  <= trans_cnt_d;
            toggle_cnt_q <= toggle_cnt_d;
        end
    end

    assign exc_s      = exc_s_q;
    assign exc_r      = exc_r_q;
    assign exc_j      = exc_j_q;
    assign exc_k      = exc_k_q;
    assign exc_t      = exc_t_q;
    assign exc_d      = exc_d_q;
    assign q_sr       = q_sr_q;
    assign q_jk       = q_jk_q;
    assign q_t        = q_t_q;
    assign mismatch   = mismatch_q;
    assign trans_cnt  = trans_cnt_q;
    assign toggle_cnt = toggle_cnt_q;

endmodule

// File: tb/tb_ff_excitation_driver.sv
// tb_ff_excitation_driver
//
// Directed bench for ff_excitation_driver. A CNT_W=8 instance and a
// CNT_W=2 instance share all inputs, so wrap and saturation can be seen
// with few transitions. Expected SR/JK terms follow the default table, or
// the don't-care-as-one table when FF_EXC_DONTCARE_ONE_EN is defined.
module tb_ff_excitation_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tgt_valid = 1'b0;
    logic tgt_q = 1'b0;
    logic clr_err = 1'b0;

    logic       tgt_ready, exc_s, exc_r, exc_j, exc_k, exc_t, exc_d;
    logic       q_sr, q_jk, q_t, exc_valid, mismatch;
    logic [7:0] trans_cnt, toggle_cnt;
    logic [1:0] dbg_state;

    logic       tgt_ready2, exc_s2, exc_r2, exc_j2, exc_k2, exc_t2, exc_d2;
    logic       q_sr2, q_jk2, q_t2, exc_valid2, mismatch2;
    logic [1:0] trans_cnt2, toggle_cnt2;
    logic [1:0] dbg_state2;

    int n_checks = 0;
    int n_errors = 0;

    // Bench model
    logic       model_q = 1'b0;
    int         exp_trans = 0;
    int         exp_tog = 0;
    logic [5:0] exp_q[$];   // {s, r, j, k, t, d}

    ff_excitation_driver #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_q(tgt_q),
        .tgt_ready(tgt_ready), .clr_err(clr_err),
        .exc_s(exc_s), .exc_r(exc_r), .exc_j(exc_j), .exc_k(exc_k),
        .exc_t(exc_t), .exc_d(exc_d), .q_sr(q_sr), .q_jk(q_jk), .q_t(q_t),
        .exc_valid(exc_valid), .mismatch(mismatch), .trans_cnt(trans_cnt),
        .toggle_cnt(toggle_cnt), .dbg_state(dbg_state)
    );

    ff_excitation_driver #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_q(tgt_q),
        .tgt_ready(tgt_ready2), .clr_err(clr_err),
        .exc_s(exc_s2), .exc_r(exc_r2), .exc_j(exc_j2), .exc_k(exc_k2),
        .exc_t(exc_t2), .exc_d(exc_d2), .q_sr(q_sr2), .q_jk(q_jk2), .q_t(q_t2),
        .exc_valid(exc_valid2), .mismatch(mismatch2), .trans_cnt(trans_cnt2),
        .toggle_cnt(toggle_cnt2), .dbg_state(dbg_state2)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected {s, r, j, k} for present state q and target t.
    function automatic logic [3:0] exp_srjk(input logic q, input logic t);
`ifdef FF_EXC_DONTCARE_ONE_EN
        case ({q, t})
            2'b00:   return 4'b0101;
            2'b01:   return 4'b1011;
            2'b10:   return 4'b0111;
            default: return 4'b1010;
        endcase
`else
        case ({q, t})
            2'b01:   return 4'b1010;
            2'b10:   return 4'b0101;
            default: return 4'b0000;
        endcase
`endif
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_trans8"}, trans_cnt, exp_trans % 256);
        check({tag, "_tog8"}, toggle_cnt, (exp_tog > 255) ? 255 : exp_tog);
        check({tag, "_trans2"}, trans_cnt2, exp_trans % 4);
        check({tag, "_tog2"}, toggle_cnt2, (exp_tog > 3) ? 3 : exp_tog);
        check({tag, "_mismatch"}, {mismatch, mismatch2}, 2'b00);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, {tgt_ready, tgt_ready2}, 2'b11);
        check({tag, "_exc"}, {exc_s, exc_r, exc_j, exc_k, exc_t, exc_d}, 6'b0);
        check({tag, "_models"}, {q_sr, q_jk, q_t}, 3'b0);
        check({tag, "_valid_mm"}, {exc_valid, mismatch}, 2'b0);
        check({tag, "_cnts"}, {trans_cnt, toggle_cnt, trans_cnt2, toggle_cnt2}, 20'h0);
    endtask

    task automatic model_reset();
        model_q = 1'b0;
        exp_trans = 0;
        exp_tog = 0;
        exp_q.delete();
    endtask

    // Driver: one complete transition. Called #1 after a rising edge with
    // the DUT in IDLE.
    task automatic send(input logic t);
        logic [5:0] v;
        exp_q.push_back({exp_srjk(model_q, t), model_q ^ t, t});
        tgt_valid = 1'b1;
        tgt_q = t;
        check("ready_idle", tgt_ready, 1'b1);
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        tgt_q = ~t;    // ignored outside IDLE
        v = exp_q.pop_front();
        check("exc_apply", {exc_s, exc_r, exc_j, exc_k, exc_t, exc_d}, v);
        check("sr_excl", exc_s & exc_r, 1'b0);
        check("ready_apply", tgt_ready, 1'b0);
        check("valid_apply", exc_valid, 1'b0);
        @(posedge clk); #1;
        check("valid_check", exc_valid, 1'b1);
        check("ready_check", tgt_ready, 1'b0);
        check("models", {q_sr, q_jk, q_t}, {3{t}});
        @(posedge clk); #1;
        exp_trans++;
        if (model_q != t) exp_tog++;
        model_q = t;
        check("valid_idle", exc_valid, 1'b0);
        check("exc_hold", {exc_s, exc_r, exc_j, exc_k, exc_t, exc_d}, v);
        check_counts("post");
    endtask

    initial begin
        logic [11:0] pat;
        int hs_count;
        logic rdy_exp;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Sequence 1,1,0,0,1: exc_t 1,0,1,0,1; toggles 3; transitions 5
        send(1'b1);
        send(1'b1);
        send(1'b0);
        send(1'b0);
        send(1'b1);
        check("seq_trans", trans_cnt, 8'd5);
        check("seq_tog", toggle_cnt, 8'd3);

        // tgt_valid held high for 12 cycles: one handshake every 3 cycles
        pat = 12'b1001_0110_0101;
        hs_count = 0;
        for (int i = 0; i < 12; i++) begin
            tgt_valid = 1'b1;
            tgt_q = pat[i];
            rdy_exp = ((i % 3) == 0);
            check("hold_ready", tgt_ready, rdy_exp);
            if (tgt_ready) hs_count++;
            if (rdy_exp) begin
                exp_trans++;
                if (model_q != pat[i]) exp_tog++;
                model_q = pat[i];
            end
            @(posedge clk); #1;
        end
        tgt_valid = 1'b0;
        check("hold_hs_count", hs_count, 4);
        check("hold_models", {q_sr, q_jk, q_t}, {3{model_q}});
        check_counts("hold");

        // Fresh reset, five toggling transitions: CNT_W=2 wraps and saturates
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_state("reset2");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(1'b1);
        send(1'b0);
        send(1'b1);
        send(1'b0);
        send(1'b1);
        check("wrap_trans2", trans_cnt2, 2'd1);
        check("sat_tog2", toggle_cnt2, 2'd3);
        check("wide_tog8", toggle_cnt, 8'd5);

        // Reset during APPLY aborts the transaction
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        tgt_valid = 1'b1;
        tgt_q = 1'b1;
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        check("abort_in_apply", tgt_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_state("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_state("abort_after");
        send(1'b1);

        // Fault in CHECK with clr_err in the same cycle: set wins
        tgt_valid = 1'b1;
        tgt_q = 1'b0;
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        @(posedge clk); #1;
        check("fault_in_check", exc_valid, 1'b1);
        force dut.q_t_q = 1'b1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        release dut.q_t_q;
        check("mm_set_wins", mismatch, 1'b1);
        check("mm_clean_inst", mismatch2, 1'b0);
        @(posedge clk); #1;
        clr_err = 1'b0;
        check("mm_cleared", mismatch, 1'b0);
        @(posedge clk); #1;
        check("mm_stays_clear", mismatch, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
